// File: rtl/kab_eic.sv
// kab_eic: external interrupt controller with mask/pending registers and a single-request handshake FSM.
// Optional KAB_EIC_EDGE_DETECT_EN: rising-edge sources with sticky pending; otherwise pending follows the sources.
module kab_eic #(
  parameter int ID_WIDTH = 1,
  parameter int NUM_SRC  = 2**ID_WIDTH
) (
  input  logic                Sys_Clock,
  input  logic                Sys_Reset,
  input  logic [NUM_SRC-1:0]  Int_Src,
  input  logic                Sys_WrEn,
  input  logic                Sys_RdEn,
  input  logic [1:0]          Sys_Address,
  input  logic [31:0]         Sys_WrData,
  output logic [31:0]         Sys_RdData,
  output logic                EIC_IntReq,
  output logic [ID_WIDTH-1:0] EIC_IntId,
  input  logic                EIC_IntAck
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // state is the debug view of the handshake FSM
  state_t              state;
  state_t              state_next;
  logic [NUM_SRC-1:0]  mask;
  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  pending_next;
  logic [NUM_SRC-1:0]  cand;
  logic [ID_WIDTH-1:0] int_id;
  logic [ID_WIDTH-1:0] sel_id;
  logic                any_cand;
  logic                load_id;
  logic                ack_fire;
  logic                wr_mask;
  logic [31:0]         rd_next;
  logic [31:0]         rd_data;

  assign wr_mask  = Sys_WrEn && (Sys_Address == 2'd0);
  assign cand     = pending & mask;
  assign any_cand = |cand;
  assign ack_fire = (state == S_REQ) && EIC_IntAck;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel_id = ID_WIDTH'(i);
    end
  end

`ifdef KAB_EIC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] src_event;
  logic [NUM_SRC-1:0] clr_w1c;
  logic [NUM_SRC-1:0] clr_ack;

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) src_prev <= '0;
    else           src_prev <= Int_Src;
  end

  assign src_event = Int_Src & ~src_prev;
  assign clr_w1c   = (Sys_WrEn && (Sys_Address == 2'd1)) ? Sys_WrData[NUM_SRC-1:0] : '0;

  always_comb begin
    clr_ack = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_ack[i] = ack_fire && (int_id == ID_WIDTH'(i));
    end
  end

  // A new event in the same cycle as a clear keeps the bit set.
  assign pending_next = (pending & ~(clr_w1c | clr_ack)) | src_event;
`else
  assign pending_next = Int_Src;
`endif

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      mask    <= '0;
      pending <= '0;
    end else begin
      pending <= pending_next;
      if (wr_mask) mask <= Sys_WrData[NUM_SRC-1:0];
    end
  end

  // Handshake: valid is EIC_IntReq, ready is EIC_IntAck; a transfer happens on a
  // cycle with both high, and EIC_IntId is frozen while EIC_IntReq is high.
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      state  <= S_IDLE;
      int_id <= '0;
    end else begin
      state <= state_next;
      if (load_id) int_id <= sel_id;
    end
  end

  always_comb begin
    state_next = state;
    load_id    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_cand) begin
          state_next = S_REQ;
          load_id    = 1'b1;
        end
      end
      S_REQ: begin
        if (EIC_IntAck) state_next = S_GAP;
      end
      S_GAP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign EIC_IntReq = (state == S_REQ);
  assign EIC_IntId  = int_id;

  // Read data is taken from current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_next = '0;
    case (Sys_Address)
      2'd0: rd_next[NUM_SRC-1:0] = mask;
      2'd1: rd_next[NUM_SRC-1:0] = pending;
      2'd2: begin
        rd_next[0]          = EIC_IntReq;
        rd_next[ID_WIDTH:1] = int_id;
      end
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset)     rd_data <= '0;
    else if (Sys_RdEn) rd_data <= rd_next;
  end

  assign Sys_RdData = rd_data;

  generate
    if (NUM_SRC < 32) begin : g_wrdata_upper
      logic unused_wrdata;
      assign unused_wrdata = ^Sys_WrData[31:NUM_SRC];
    end
  endgenerate

endmodule

// File: tb/tb_kab_eic.sv
// tb_kab_eic: directed self-checking bench for kab_eic (ID_WIDTH=1, two sources).
// Expectations adapt to KAB_EIC_EDGE_DETECT_EN where edge and level behaviour differ.
module tb_kab_eic;

`ifdef KAB_EIC_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  src;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        int_req;
  logic [0:0]  int_id;
  logic        int_ack;

  int total;
  int bad;
  logic [31:0] d;

  kab_eic #(.ID_WIDTH(1), .NUM_SRC(2)) dut (
    .Sys_Clock   (clk),
    .Sys_Reset   (rst),
    .Int_Src     (src),
    .Sys_WrEn    (wr_en),
    .Sys_RdEn    (rd_en),
    .Sys_Address (addr),
    .Sys_WrData  (wr_data),
    .Sys_RdData  (rd_data),
    .EIC_IntReq  (int_req),
    .EIC_IntId   (int_id),
    .EIC_IntAck  (int_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers: all are entered and left at a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic re, input logic we, input logic [1:0] a,
                     input logic [31:0] wd, output logic [31:0] rdv);
    rd_en   = re;
    wr_en   = we;
    addr    = a;
    wr_data = wd;
    tick(1);
    rd_en = 1'b0;
    wr_en = 1'b0;
    rdv   = rd_data;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b0, 1'b1, a, wd, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] rdv);
    bus(1'b1, 1'b0, a, 32'h0, rdv);
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1; src = 2'b00; wr_en = 1'b0; rd_en = 1'b0;
    addr = 2'd0; wr_data = 32'h0; int_ack = 1'b0;
    tick(3);
    check("rst_req", {31'h0, int_req}, 32'h0);
    check("rst_id", {31'h0, int_id}, 32'h0);
    check("rst_rd", rd_data, 32'h0);
    rst = 1'b0;
    tick(1);
    rd(2'd0, d); check("rst_mask", d, 32'h0);
    rd(2'd1, d); check("rst_pend", d, 32'h0);
    rd(2'd2, d); check("rst_status", d, 32'h0);

    // single source 1 event
    wr(2'd0, 32'h3);
    src = 2'b10; tick(1);
    check("s1_req_early", {31'h0, int_req}, 32'h0);
    src = 2'b00; tick(1);
    check("s1_req", {31'h0, int_req}, 32'h1);
    check("s1_id", {31'h0, int_id}, 32'h1);
    rd(2'd2, d); check("s1_status", d, 32'h3);
    rd(2'd1, d); check("s1_pend", d, EDGE ? 32'h2 : 32'h0);
    ack_pulse();
    check("s1_gap", {31'h0, int_req}, 32'h0);
    tick(2);
    check("s1_idle", {31'h0, int_req}, 32'h0);

    // both sources together: lowest index first, then the other after the gap
    src = 2'b11; tick(1);
    check("both_req_early", {31'h0, int_req}, 32'h0);
    tick(1);
    check("both_req0", {31'h0, int_req}, 32'h1);
    check("both_id0", {31'h0, int_id}, 32'h0);
    src = EDGE ? 2'b00 : 2'b10;
    ack_pulse();
    check("both_gap", {31'h0, int_req}, 32'h0);
    tick(1);
    check("both_idle", {31'h0, int_req}, 32'h0);
    tick(1);
    check("both_req1", {31'h0, int_req}, 32'h1);
    check("both_id1", {31'h0, int_id}, 32'h1);
    rd(2'd1, d); check("both_pend_a", d, 32'h2);
    src = 2'b00;
    ack_pulse();
    rd(2'd1, d); check("both_pend_b", d, 32'h0);
    tick(2);
    check("both_quiet", {31'h0, int_req}, 32'h0);

    // masked pending source, then unmask
    wr(2'd0, 32'h0);
    src = 2'b01; tick(1);
    src = EDGE ? 2'b00 : 2'b01; tick(2);
    check("mask_noreq", {31'h0, int_req}, 32'h0);
    rd(2'd1, d); check("mask_pend", d, 32'h1);
    wr(2'd0, 32'h1);
    check("unmask_wr", {31'h0, int_req}, 32'h0);
    tick(1);
    check("unmask_req", {31'h0, int_req}, 32'h1);
    check("unmask_id", {31'h0, int_id}, 32'h0);

    // mask cleared during a request: request held until ack, no re-request
    wr(2'd0, 32'h0);
    check("hold_req_a", {31'h0, int_req}, 32'h1);
    tick(2);
    check("hold_req_b", {31'h0, int_req}, 32'h1);
    check("hold_id", {31'h0, int_id}, 32'h0);
    src = 2'b00;
    ack_pulse();
    check("hold_gap", {31'h0, int_req}, 32'h0);
    tick(3);
    check("hold_norereq", {31'h0, int_req}, 32'h0);
    rd(2'd2, d); check("hold_status", d, 32'h0);

    // source 0 still asserted (level) or re-edged with the ack (edge): new request after gap
    wr(2'd0, 32'h1);
    src = 2'b01; tick(1);
    src = EDGE ? 2'b00 : 2'b01; tick(1);
    check("again_req", {31'h0, int_req}, 32'h1);
    src = 2'b01;
    ack_pulse();
    src = EDGE ? 2'b00 : 2'b01;
    check("again_gap", {31'h0, int_req}, 32'h0);
    rd(2'd1, d); check("again_pend", d, 32'h1);
    check("again_idle", {31'h0, int_req}, 32'h0);
    tick(1);
    check("again_req2", {31'h0, int_req}, 32'h1);
    check("again_id2", {31'h0, int_id}, 32'h0);
    src = 2'b00;
    ack_pulse();
    tick(2);

    // ack in IDLE ignored, write-1-to-clear, set wins over clear
    wr(2'd0, 32'h0);
    src = 2'b01; tick(1);
    src = EDGE ? 2'b00 : 2'b01; tick(1);
    ack_pulse();
    check("ackidle_req", {31'h0, int_req}, 32'h0);
    rd(2'd1, d); check("ackidle_pend", d, 32'h1);
    wr(2'd1, 32'h1);
    rd(2'd1, d); check("w1c_pend", d, EDGE ? 32'h0 : 32'h1);
    src = 2'b01;
    wr(2'd1, 32'h1);
    src = EDGE ? 2'b00 : 2'b01;
    rd(2'd1, d); check("setwins_pend", d, 32'h1);

    // register map details
    wr(2'd0, 32'hFFFF_FFFE);
    rd(2'd0, d); check("mask_bits", d, 32'h2);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); check("addr3_rd", d, 32'h0);
    rd(2'd0, d);
    addr = 2'd1;
    tick(2);
    check("rd_hold", rd_data, 32'h2);
    bus(1'b1, 1'b1, 2'd0, 32'h1, d);
    check("rw_same", d, 32'h2);

    // reset during a request
    tick(1);
    check("rstreq_req", {31'h0, int_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstreq_async_req", {31'h0, int_req}, 32'h0);
    check("rstreq_async_rd", rd_data, 32'h0);
    tick(2);
    rst = 1'b0;
    src = 2'b00;
    tick(1);
    check("rstreq_after", {31'h0, int_req}, 32'h0);
    rd(2'd0, d); check("rstreq_mask", d, 32'h0);
    rd(2'd1, d); check("rstreq_pend", d, 32'h0);
    rd(2'd2, d); check("rstreq_status", d, 32'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
